// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned divider using repeated subtraction.
// The dividend and divisor arrive on a shared bus on the two cycles after start.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             dz
);
  typedef enum logic [2:0] {IDLE, LDA, LDB, CHK, SUB, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] divisor;
  assign done = state == DONE;
  assign busy = state inside {LDA, LDB, CHK, SUB};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      quotient  <= '0;
      remainder <= '0;
      divisor   <= '0;
      dz        <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= start ? LDA : IDLE;
        LDA: begin
          remainder <= data_in;
          state     <= LDB;
        end
        LDB: begin
          divisor  <= data_in;
          quotient <= '0;
          dz       <= 1'b0;
          state    <= CHK;
        end
        CHK: begin
          // a zero divisor saturates the quotient and keeps the dividend as remainder
          if (divisor == '0) begin
            dz       <= 1'b1;
            quotient <= '1;
            state    <= DONE;
          end else begin
            state <= SUB;
          end
        end
        SUB: begin
          if (remainder >= divisor) begin
            remainder <= remainder - divisor;
            quotient  <= quotient + 1'b1;
          end else begin
            state <= DONE;
          end
        end
        DONE: state <= start ? LDA : DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider; expected results are queued
// as operands are driven and checked when done rises.
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] quotient, remainder;
  logic        done, busy, dz;
  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          lat;
  } exp_t;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_q = '0;

  seq_divider #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
    .quotient(quotient), .remainder(remainder), .done(done), .busy(busy), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input bit hold);
    exp_t e;
    start = 1'b1;
    @(posedge clk); #1;
    start = hold;
    data_in = a;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || quotient !== last_q) begin
      errors++;
      $display("FAIL e0_handshake: done=%b busy=%b q=%h, required done=0 busy=1 q=%h", done, busy, quotient, last_q);
    end
    @(posedge clk); #1;
    data_in = b;
    checks++;
    if (remainder !== a || quotient !== last_q) begin
      errors++;
      $display("FAIL e1_load: r=%h q=%h, required r=%h q=%h", remainder, quotient, a, last_q);
    end
    @(posedge clk); #1;
    data_in = 16'($urandom);
    checks++;
    if (quotient !== 16'h0 || dz !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL e2_load: q=%h dz=%b busy=%b, required q=0 dz=0 busy=1", quotient, dz, busy);
    end
    e.q   = (b == 0) ? 16'hFFFF : a / b;
    e.r   = (b == 0) ? a : a % b;
    e.dz  = (b == 0);
    e.lat = (b == 0) ? 3 : int'(e.q) + 4;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int pulse_at);
    exp_t e;
    int   n;
    bit   bad;
    n = 2;
    bad = 0;
    while (done !== 1'b1 && n < 70000) begin
      @(posedge clk); #1;
      n++;
      if (done !== 1'b1 && busy !== 1'b1) bad = 1;
      if (done === 1'b1 && busy !== 1'b0) bad = 1;
      if (pulse_at != 0 && n == pulse_at) start = 1'b1;
      if (pulse_at != 0 && n == pulse_at + 1) start = 1'b0;
    end
    checks++;
    if (done !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL done_timeout: done=%b after %0d edges, pending=%0d, required done=1", done, n, sb.size());
      return;
    end
    e = sb.pop_front();
    checks++;
    if (quotient !== e.q || remainder !== e.r || dz !== e.dz) begin
      errors++;
      $display("FAIL result: q=%h r=%h dz=%b, required q=%h r=%h dz=%b", quotient, remainder, dz, e.q, e.r, e.dz);
    end
    checks++;
    if (n != e.lat) begin
      errors++;
      $display("FAIL latency: done after E%0d, required E%0d", n, e.lat);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL busy_done: busy/done overlap or gap seen, required busy=~done during operation");
    end
    last_q = e.q;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b1;
    data_in = 16'hBEEF;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (quotient !== 0 || remainder !== 0 || done !== 0 || busy !== 0 || dz !== 0) begin
      errors++;
      $display("FAIL reset_state: q=%h r=%h done=%b busy=%b dz=%b, required all 0", quotient, remainder, done, busy, dz);
    end
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 0 || done !== 0) begin
      errors++;
      $display("FAIL idle_hold: busy=%b done=%b, required 0 0", busy, done);
    end
    last_q = '0;
  endtask

  task automatic test_basic;
    start_op(16'd100, 16'd7, 1'b0);
    wait_done(0);
  endtask

  task automatic test_small;
    start_op(16'd3, 16'd10, 1'b0);
    wait_done(0);
  endtask

  task automatic test_div_zero;
    start_op(16'd5, 16'd0, 1'b0);
    wait_done(0);
  endtask

  task automatic test_max;
    start_op(16'd65535, 16'd1, 1'b0);
    wait_done(0);
  endtask

  task automatic test_ignore_start;
    start_op(16'd200, 16'd3, 1'b0);
    wait_done(6);
  endtask

  task automatic test_abort_reset;
    start_op(16'd1000, 16'd1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (quotient !== 0 || remainder !== 0 || done !== 0 || busy !== 0 || dz !== 0) begin
      errors++;
      $display("FAIL abort_reset: q=%h r=%h done=%b busy=%b dz=%b, required all 0", quotient, remainder, done, busy, dz);
    end
    rst_n = 1'b1;
    sb.delete();
    last_q = '0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 0 || done !== 0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b done=%b, required 0 0", busy, done);
    end
    start_op(16'd9, 16'd9, 1'b0);
    wait_done(0);
  endtask

  task automatic test_back_to_back;
    start_op(16'd100, 16'd7, 1'b1);
    wait_done(0);
    start_op(16'd50, 16'd5, 1'b0);
    wait_done(0);
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || quotient !== 16'd10) begin
      errors++;
      $display("FAIL done_hold: done=%b q=%h, required done=1 q=000a", done, quotient);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_small();
    test_div_zero();
    test_max();
    test_ignore_start();
    test_abort_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
